// File: rtl/xrnic_cm_pkg.sv
// Shared types and constants for the RoCE CM connection controller:
// state encoding, CM attribute IDs and default timing limits.
package xrnic_cm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_TX   = 3'd1,
    REP_WAIT = 3'd2,
    RTU_TX   = 3'd3,
    REP_TX   = 3'd4,
    RTU_WAIT = 3'd5,
    ESTAB    = 3'd6,
    ERROR    = 3'd7
  } cm_st_e;

  // MAD attribute IDs of the CM messages this controller sequences
  localparam logic [15:0] CM_ATTR_REQ = 16'h0010;
  localparam logic [15:0] CM_ATTR_REJ = 16'h0012;
  localparam logic [15:0] CM_ATTR_REP = 16'h0013;
  localparam logic [15:0] CM_ATTR_RTU = 16'h0014;

  localparam logic [31:0] CM_TIMEOUT_DEFAULT   = 32'd1_000_000;
  localparam logic [3:0]  CM_MAX_RETRY_DEFAULT = 4'd3;

  function automatic logic cm_is_wait(input cm_st_e st);
    return (st == REP_WAIT) || (st == RTU_WAIT);
  endfunction

endpackage

// File: rtl/xrnic_cm_timer.sv
// Peer-response timer: counts while enabled, clears on request, and flags
// the last cycle of the timeout window. Holds at terminal count (no wrap).
module xrnic_cm_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic core_clk,
  input  logic core_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_reg;

  assign expired = enable && (count_reg == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 32'd1;
    end
  end

endmodule

// File: rtl/xrnic_cm_conn_ctrl.sv
// RoCE CM handshake sequencer driving the one-hot tx enables of the CM packet
// generator. Build with CM_RETRY_EN defined to resend on timeout before ERROR.
module xrnic_cm_conn_ctrl
  import xrnic_cm_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = CM_TIMEOUT_DEFAULT,
  parameter logic [3:0]  MAX_RETRY      = CM_MAX_RETRY_DEFAULT
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       conn_start,
  input  logic       conn_abort,
  input  logic       rx_req_valid,
  input  logic       rx_rep_valid,
  input  logic       rx_rtu_valid,
  input  logic       rx_rej_valid,
  input  logic       tx_done,
  output logic       cm_req_tx_en,
  output logic       cm_reply_tx_en,
  output logic       cm_rtu_tx_en,
  output logic [2:0] conn_state,
  output logic       conn_established,
  output logic       conn_error,
  output logic [3:0] retry_cnt
);

`ifdef CM_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  cm_st_e     state_reg;
  cm_st_e     state_next;
  logic [3:0] retry_next;
  logic       timeout;

  assign conn_state = state_reg;

  xrnic_cm_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .clear    (state_next != state_reg),
    .enable   (cm_is_wait(state_reg)),
    .expired  (timeout)
  );

  always_comb begin
    state_next = state_reg;
    retry_next = retry_cnt;
    if (conn_abort) begin
      state_next = IDLE;
      retry_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (conn_start) begin
            state_next = REQ_TX;
            retry_next = '0;
          end else if (rx_req_valid) begin
            state_next = REP_TX;
            retry_next = '0;
          end
        end
        REQ_TX:   if (tx_done) state_next = REP_WAIT;
        REP_TX:   if (tx_done) state_next = RTU_WAIT;
        RTU_TX:   if (tx_done) state_next = ESTAB;
        // rx pulses are checked before the timer so a same-cycle reply wins
        REP_WAIT: begin
          if (rx_rep_valid) begin
            state_next = RTU_TX;
          end else if (rx_rej_valid) begin
            state_next = ERROR;
          end else if (timeout) begin
            if (RETRY_EN && (retry_cnt < MAX_RETRY)) begin
              state_next = REQ_TX;
              retry_next = retry_cnt + 4'd1;
            end else begin
              state_next = ERROR;
            end
          end
        end
        RTU_WAIT: begin
          if (rx_rtu_valid) begin
            state_next = ESTAB;
          end else if (rx_rej_valid) begin
            state_next = ERROR;
          end else if (timeout) begin
            if (RETRY_EN && (retry_cnt < MAX_RETRY)) begin
              state_next = REP_TX;
              retry_next = retry_cnt + 4'd1;
            end else begin
              state_next = ERROR;
            end
          end
        end
        ESTAB: begin
          if (rx_req_valid) begin
            state_next = REP_TX;
            retry_next = '0;
          end
        end
        ERROR: begin
          if (conn_start) begin
            state_next = REQ_TX;
            retry_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they line up with state_reg
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_reg        <= IDLE;
      cm_req_tx_en     <= 1'b0;
      cm_reply_tx_en   <= 1'b0;
      cm_rtu_tx_en     <= 1'b0;
      conn_established <= 1'b0;
      conn_error       <= 1'b0;
      retry_cnt        <= '0;
    end else begin
      state_reg        <= state_next;
      cm_req_tx_en     <= (state_next == REQ_TX);
      cm_reply_tx_en   <= (state_next == REP_TX);
      cm_rtu_tx_en     <= (state_next == RTU_TX);
      conn_established <= (state_next == ESTAB);
      conn_error       <= (state_next == ERROR);
      retry_cnt        <= RETRY_EN ? retry_next : 4'd0;
    end
  end

endmodule

// File: tb/tb_xrnic_cm_conn_ctrl.sv
// Directed bench for xrnic_cm_conn_ctrl (TIMEOUT_CYCLES=100, MAX_RETRY=2);
// expectations follow CM_RETRY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_xrnic_cm_conn_ctrl;
  import xrnic_cm_pkg::*;

  logic       core_clk = 1'b0;
  logic       core_rst = 1'b1;
  logic       conn_start = 1'b0, conn_abort = 1'b0;
  logic       rx_req_valid = 1'b0, rx_rep_valid = 1'b0;
  logic       rx_rtu_valid = 1'b0, rx_rej_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic       cm_req_tx_en, cm_reply_tx_en, cm_rtu_tx_en;
  logic [2:0] conn_state;
  logic       conn_established, conn_error;
  logic [3:0] retry_cnt;

  localparam logic [6:0] P_START = 7'b1000000;
  localparam logic [6:0] P_ABORT = 7'b0100000;
  localparam logic [6:0] P_REQ   = 7'b0010000;
  localparam logic [6:0] P_REP   = 7'b0001000;
  localparam logic [6:0] P_RTU   = 7'b0000100;
  localparam logic [6:0] P_REJ   = 7'b0000010;
  localparam logic [6:0] P_TXD   = 7'b0000001;

  always #5 core_clk = ~core_clk;

  xrnic_cm_conn_ctrl #(
    .TIMEOUT_CYCLES (32'd100),
    .MAX_RETRY      (4'd2)
  ) dut (
    .core_clk         (core_clk),
    .core_rst         (core_rst),
    .conn_start       (conn_start),
    .conn_abort       (conn_abort),
    .rx_req_valid     (rx_req_valid),
    .rx_rep_valid     (rx_rep_valid),
    .rx_rtu_valid     (rx_rtu_valid),
    .rx_rej_valid     (rx_rej_valid),
    .tx_done          (tx_done),
    .cm_req_tx_en     (cm_req_tx_en),
    .cm_reply_tx_en   (cm_reply_tx_en),
    .cm_rtu_tx_en     (cm_rtu_tx_en),
    .conn_state       (conn_state),
    .conn_established (conn_established),
    .conn_error       (conn_error),
    .retry_cnt        (retry_cnt)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic watch_req = 1'b0;
  logic req_seen  = 1'b0;

  always @(posedge core_clk) begin
    if (watch_req && cm_req_tx_en) req_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // packed view {state, req, rep, rtu, estab, error, retry}
  task automatic expect_outs(input string tag, input cm_st_e st, input logic [2:0] en,
                             input logic est, input logic err, input logic [3:0] rty);
    check(tag, {20'd0, conn_state, cm_req_tx_en, cm_reply_tx_en, cm_rtu_tx_en,
                conn_established, conn_error, retry_cnt},
               {20'd0, st, en, est, err, rty});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {conn_start, conn_abort, rx_req_valid, rx_rep_valid, rx_rtu_valid, rx_rej_valid, tx_done} = v;
    tick(1);
    {conn_start, conn_abort, rx_req_valid, rx_rep_valid, rx_rtu_valid, rx_rej_valid, tx_done} = '0;
  endtask

  initial begin
    tick(2);
    expect_outs("reset", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);
    core_rst = 1'b0;
    tick(1);

    // active happy path
    drive(P_START);
    expect_outs("act_start", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd0);
    tick(19);
    expect_outs("act_req_hold", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd0);
    drive(P_TXD);
    expect_outs("act_rep_wait", REP_WAIT, 3'b000, 1'b0, 1'b0, 4'd0);
    tick(50);
    drive(P_REP);
    expect_outs("act_rtu_tx", RTU_TX, 3'b001, 1'b0, 1'b0, 4'd0);
    tick(5);
    expect_outs("act_rtu_hold", RTU_TX, 3'b001, 1'b0, 1'b0, 4'd0);
    drive(P_TXD);
    expect_outs("act_estab", ESTAB, 3'b000, 1'b1, 1'b0, 4'd0);
    drive(P_START);
    expect_outs("start_ignored_estab", ESTAB, 3'b000, 1'b1, 1'b0, 4'd0);
    drive(P_ABORT);
    expect_outs("abort_estab", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);

    // passive path
    watch_req = 1'b1;
    drive(P_REQ);
    expect_outs("pas_rep_tx", REP_TX, 3'b010, 1'b0, 1'b0, 4'd0);
    drive(P_RTU);
    expect_outs("pas_rtu_dropped", REP_TX, 3'b010, 1'b0, 1'b0, 4'd0);
    drive(P_TXD);
    expect_outs("pas_rtu_wait", RTU_WAIT, 3'b000, 1'b0, 1'b0, 4'd0);
    tick(10);
    drive(P_RTU);
    expect_outs("pas_estab", ESTAB, 3'b000, 1'b1, 1'b0, 4'd0);
    drive(P_REQ);
    expect_outs("pas_reconnect", REP_TX, 3'b010, 1'b0, 1'b0, 4'd0);
    watch_req = 1'b0;
    check("pas_req_never", {31'd0, req_seen}, 32'd0);
    drive(P_ABORT);

    // timeout
    drive(P_START);
    drive(P_TXD);
    tick(99);
    expect_outs("to_last_wait_cycle", REP_WAIT, 3'b000, 1'b0, 1'b0, 4'd0);
    tick(1);
`ifdef CM_RETRY_EN
    expect_outs("to_resend1", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd1);
    drive(P_TXD);
    tick(100);
    expect_outs("to_resend2", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd2);
    drive(P_TXD);
    tick(100);
    expect_outs("to_error", ERROR, 3'b000, 1'b0, 1'b1, 4'd2);
    drive(P_REQ);
    expect_outs("err_req_ignored", ERROR, 3'b000, 1'b0, 1'b1, 4'd2);
`else
    expect_outs("to_error", ERROR, 3'b000, 1'b0, 1'b1, 4'd0);
    drive(P_REQ);
    expect_outs("err_req_ignored", ERROR, 3'b000, 1'b0, 1'b1, 4'd0);
`endif
    drive(P_START);
    expect_outs("err_restart", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd0);

    // reject, then reply racing the timeout
    drive(P_TXD);
    drive(P_REJ);
    expect_outs("reject", ERROR, 3'b000, 1'b0, 1'b1, 4'd0);
    drive(P_START);
    drive(P_TXD);
    drive(P_START);
    expect_outs("start_ignored_wait", REP_WAIT, 3'b000, 1'b0, 1'b0, 4'd0);
    tick(98);
    drive(P_REP);
    expect_outs("race_rep_wins", RTU_TX, 3'b001, 1'b0, 1'b0, 4'd0);
    tick(1);
    expect_outs("race_no_resend", RTU_TX, 3'b001, 1'b0, 1'b0, 4'd0);

    // abort / simultaneous / stray
    drive(P_ABORT);
    drive(P_START);
    drive(P_ABORT);
    expect_outs("abort_req_tx", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);
    drive(P_START | P_REQ);
    expect_outs("start_wins", REQ_TX, 3'b100, 1'b0, 1'b0, 4'd0);
    drive(P_ABORT);
    drive(P_TXD);
    expect_outs("stray_tx_done", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);

    // asynchronous reset in RTU_WAIT
    drive(P_REQ);
    drive(P_TXD);
    tick(3);
    expect_outs("pre_rst_rtu_wait", RTU_WAIT, 3'b000, 1'b0, 1'b0, 4'd0);
    #2 core_rst = 1'b1;
    #1;
    expect_outs("rst_async", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);
    tick(2);
    core_rst = 1'b0;
    tick(2);
    expect_outs("post_rst_idle", IDLE, 3'b000, 1'b0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
